// File: rtl/approx_div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned CNT_W_DEF = $clog2(W_DEF + 1);

  // Counter width able to hold the value w itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/approx_seq_divider_div_step.sv
// One restoring-division stage: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] rem,
  input  logic         next_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] new_rem,
  output logic         q_bit
);

  logic [W:0] t;

  // rem < divisor on entry, so t - divisor always fits back into W bits.
  always_comb begin
    t       = {rem, next_bit};
    q_bit   = (t >= {1'b0, divisor});
    new_rem = q_bit ? W'(t - {1'b0, divisor}) : t[W-1:0];
  end

endmodule

// File: rtl/approx_seq_divider.sv
// Iterative 2W/W restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define APPROX_DIV_EN to skip the low APPROX_BITS quotient bits (truncated quotient, remainder 0).
module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned APPROX_BITS = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int unsigned CNT_W = cnt_width(W);
`ifdef APPROX_DIV_EN
  localparam int unsigned ITERS = W - APPROX_BITS;
`else
  localparam int unsigned ITERS = W;
`endif

  if (APPROX_BITS >= W) begin : g_bad_cfg
    $error("APPROX_BITS must be in 0..W-1");
  end

  state_t           state;
  logic [W-1:0]     rem_q;
  logic [W-1:0]     shift_q;
  logic [W-1:0]     div_q;
  logic [CNT_W-1:0] cnt;

  logic [W-1:0]     step_rem;
  logic             step_q;
  logic [W-1:0]     shift_nxt;

  div_step #(.W(W)) u_step (
    .rem      (rem_q),
    .next_bit (shift_q[W-1]),
    .divisor  (div_q),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  // Dividend low bits leave at the MSB while quotient bits enter at the LSB.
  assign shift_nxt = W'({shift_q, step_q});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      rem_q     <= '0;
      shift_q   <= '0;
      div_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_q    <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[W-1:0];
            end else if (dividend[2*W-1:W] >= divisor) begin
              state     <= DONE;
              out_valid <= 1'b1;
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[W-1:0];
            end else begin
              state   <= RUN;
              rem_q   <= dividend[2*W-1:W];
              shift_q <= dividend[W-1:0];
              cnt     <= CNT_W'(ITERS);
            end
          end
        end

        RUN: begin
          rem_q   <= step_rem;
          shift_q <= shift_nxt;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef APPROX_DIV_EN
            quotient  <= W'(shift_nxt << APPROX_BITS);
            remainder <= '0;
`else
            quotient  <= shift_nxt;
            remainder <= step_rem;
`endif
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_seq_divider.sv
// Randomized and directed checks of approx_seq_divider against an arithmetic reference model.
module tb_approx_seq_divider;

  localparam int W  = 8;
  localparam int AB = 3;
`ifdef APPROX_DIV_EN
  localparam int ITERS = W - AB;
`else
  localparam int ITERS = W;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  int n_vec = 0;
  int n_bad = 0;

  approx_seq_divider #(.W(W), .APPROX_BITS(AB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain integer division with the block's error conventions layered on top.
  function automatic void ref_div(input int n, input int d,
                                  output int q, output int r, output int dz,
                                  output int ov, output int lat);
    dz = 0; ov = 0;
    if (d == 0) begin
      dz = 1; q = 255; r = n % 256; lat = 0;
    end else if (n / 256 >= d) begin
      ov = 1; q = 255; r = n % 256; lat = 0;
    end else begin
      q = n / d;
      r = n % d;
`ifdef APPROX_DIV_EN
      q = (q / (1 << AB)) * (1 << AB);
      r = 0;
`endif
      lat = ITERS;
    end
  endfunction

  task automatic run_op(input int n, input int d, input int hold, input string tag);
    int q, r, dz, ov, lat_exp, lat, k;
    ref_div(n, d, q, r, dz, ov, lat_exp);
    @(negedge clk);
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 1);
    dividend = 16'(n);
    divisor  = 8'(d);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    // lat counts edges after the accepting edge; error results appear on that edge itself.
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(lat_exp));
    check({tag, ".q"}, 32'(quotient), 32'(q));
    check({tag, ".r"}, 32'(remainder), 32'(r));
    check({tag, ".dz"}, 32'(div_zero), 32'(dz));
    check({tag, ".ov"}, 32'(overflow), 32'(ov));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(posedge clk);
      #1;
      check({tag, ".hold_q"}, 32'(quotient), 32'(q));
      check({tag, ".hold_r"}, 32'(remainder), 32'(r));
      check({tag, ".hold_flags"}, 32'({div_zero, overflow}), 32'({dz[0], ov[0]}));
      check({tag, ".hold_rdy"}, 32'({out_valid, in_ready}), 32'b10);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".taken"}, 32'({out_valid, div_zero, overflow}), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b, p, n, d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.in_ready", 32'(in_ready), 1);
    check("rst.qr", 32'({quotient, remainder}), 0);
    check("rst.flags", 32'({div_zero, overflow}), 0);
    rst_n = 1'b1;

    run_op(20000, 100, 0, "exact_200");
    run_op(1000, 7, 0, "div_1000_7");
    run_op(65535, 255, 0, "overflow");
    run_op(1234, 0, 0, "div_zero");
    run_op(30000, 123, 10, "stall");
    run_op(255, 1, 0, "div_by_one");
    run_op(25500, 101, 0, "hi_below_div");

    // Reset lands on the 4th RUN edge and must discard the operation.
    @(negedge clk);
    dividend = 16'd30000;
    divisor  = 8'd123;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.out_valid", 32'(out_valid), 0);
    check("midrst.in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(30000, 123, 0, "after_rst");

    // Products of an approximate multiplier: exact a*b with small low-bit error.
    for (int i = 0; i < 1500; i++) begin
      do begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(1, 255));
        p = (a * b) ^ int'($urandom_range(0, 3));
      end while (p / 256 >= b);
      run_op(p, b, int'($urandom_range(0, 1)), "sweep");
    end

    // Unconstrained operands exercise the error paths too.
    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 65535));
      d = (i % 16 == 0) ? 0 : int'($urandom_range(0, 255));
      run_op(n, d, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
